pwm_regbank: RTL and testbench



---
 rtl/pwm_regbank_pkg.sv | 11 +
 rtl/pwm_shadow_ch.sv | 74 +++++++
 rtl/pwm_regbank.sv | 79 +++++++
 tb/tb_pwm_regbank.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_regbank_pkg.sv
// pwm_regbank_pkg: shared address-map offsets, CTRL bit positions and channel FSM states
package pwm_regbank_pkg;
   localparam int STRIDE = 4;
   localparam int OFS_B0 = 0;
   localparam int OFS_B1 = 1;
   localparam int OFS_B2 = 2;
   localparam int OFS_COMMIT = 3;
   localparam int CTRL_COMMIT_ALL_BIT = 0;
   localparam int CTRL_IMM_BIT = 1;
   typedef enum logic {IDLE, PENDING} ch_state_e;
endpackage

// File: rtl/pwm_shadow_ch.sv
// pwm_shadow_ch: one channel of scratch -> staged -> active compare shadowing
// Ports: byte_we/wdata load scratch bytes; commit snapshots scratch into staged;
// period_start or imm_mode applies staged to cmp; pending/update report status.
// Optional macro PWM_CMP_CLAMP_EN clamps staged to [CMP_MIN, CMP_MAX] and adds clamp_hit.
module pwm_shadow_ch
   import pwm_regbank_pkg::*;
#(
   parameter int PWMWIDTH = 19,
   parameter logic [PWMWIDTH-1:0] RESET_CMP = PWMWIDTH'(19'h50001)
`ifdef PWM_CMP_CLAMP_EN
   ,
   parameter logic [PWMWIDTH-1:0] CMP_MIN = '0,
   parameter logic [PWMWIDTH-1:0] CMP_MAX = '1
`endif
)(
   input  logic                clk1d,
   input  logic                rst,
   input  logic [2:0]          byte_we,
   input  logic [7:0]          wdata,
   input  logic                commit,
   input  logic                imm_mode,
   input  logic                period_start,
   output logic [PWMWIDTH-1:0] cmp,
   output logic                pending,
   output logic                update
`ifdef PWM_CMP_CLAMP_EN
   ,
   output logic                clamp_hit
`endif
);
   logic [PWMWIDTH-1:0] scratch, scratch_d, staged, staged_d;
   ch_state_e state, state_d;
   logic apply, applied;
   for (genvar i = 0; i < PWMWIDTH; i++) begin : g_bit
      assign scratch_d[i] = byte_we[i/8] ? wdata[i%8] : scratch[i];
   end
`ifdef PWM_CMP_CLAMP_EN
   logic clamp_d;
   assign clamp_d = scratch < CMP_MIN || scratch > CMP_MAX;
   assign staged_d = scratch < CMP_MIN ? CMP_MIN : scratch > CMP_MAX ? CMP_MAX : scratch;
`else
   assign staged_d = scratch;
`endif
   // a boundary only ever applies what was staged before this cycle; a
   // simultaneous commit keeps the channel pending for the next boundary
   always_comb begin
      apply = state == PENDING && (period_start || imm_mode);
      state_d = commit ? PENDING : apply ? IDLE : state;
   end
   always_ff @(posedge clk1d or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_d;
   assign pending = state == PENDING;
   always_ff @(posedge clk1d or posedge rst)
      if (rst) begin
         scratch <= RESET_CMP;
         staged <= RESET_CMP;
         cmp <= RESET_CMP;
         applied <= 1'b0;
         update <= 1'b0;
`ifdef PWM_CMP_CLAMP_EN
         clamp_hit <= 1'b0;
`endif
      end else begin
         scratch <= scratch_d;
         applied <= apply;
         update <= applied;
         if (commit) staged <= staged_d;
         if (apply) cmp <= staged;
`ifdef PWM_CMP_CLAMP_EN
         if (commit) clamp_hit <= clamp_d;
`endif
      end
endmodule

// File: rtl/pwm_regbank.sv
// pwm_regbank: multi-channel compare register bank between i2cregif and the PWM cores
// Ports: reg_addr/reg_data/reg_valid byte-write bus; period_start per-channel boundary;
// cmp_out packed active compares; pending/update per-channel status; addr_err unmapped write.
// Optional macro PWM_CMP_CLAMP_EN adds commit-time clamping and the clamp_hit output.
module pwm_regbank
   import pwm_regbank_pkg::*;
#(
   parameter int NCH = 2,
   parameter int PWMWIDTH = 19,
   parameter int REGBITS = 4,
   parameter logic [PWMWIDTH-1:0] RESET_CMP = PWMWIDTH'(19'h50001)
`ifdef PWM_CMP_CLAMP_EN
   ,
   parameter logic [PWMWIDTH-1:0] CMP_MIN = '0,
   parameter logic [PWMWIDTH-1:0] CMP_MAX = '1
`endif
)(
   input  logic                    clk1d,
   input  logic                    rst,
   input  logic [REGBITS-1:0]      reg_addr,
   input  logic [7:0]              reg_data,
   input  logic                    reg_valid,
   input  logic [NCH-1:0]          period_start,
   output logic [NCH*PWMWIDTH-1:0] cmp_out,
   output logic [NCH-1:0]          pending,
   output logic [NCH-1:0]          update,
   output logic                    addr_err
`ifdef PWM_CMP_CLAMP_EN
   ,
   output logic [NCH-1:0]          clamp_hit
`endif
);
   localparam logic [REGBITS-1:0] CTRL = REGBITS'(STRIDE*NCH);
   logic ctrl_wr, commit_all, imm_mode;
   assign ctrl_wr = reg_valid && reg_addr == CTRL;
   assign commit_all = ctrl_wr && reg_data[CTRL_COMMIT_ALL_BIT];
   // imm_mode is registered, so a CTRL write that sets it together with
   // commit-all governs the apply one cycle later
   always_ff @(posedge clk1d or posedge rst)
      if (rst) begin
         imm_mode <= 1'b0;
         addr_err <= 1'b0;
      end else begin
         addr_err <= reg_valid && reg_addr > CTRL;
         if (ctrl_wr) imm_mode <= reg_data[CTRL_IMM_BIT];
      end
   for (genvar c = 0; c < NCH; c++) begin : g_ch
      logic [2:0] byte_we;
      logic commit;
      assign byte_we[0] = reg_valid && reg_addr == REGBITS'(STRIDE*c + OFS_B0);
      assign byte_we[1] = reg_valid && reg_addr == REGBITS'(STRIDE*c + OFS_B1);
      assign byte_we[2] = reg_valid && reg_addr == REGBITS'(STRIDE*c + OFS_B2);
      assign commit = commit_all || (reg_valid && reg_addr == REGBITS'(STRIDE*c + OFS_COMMIT));
      pwm_shadow_ch #(
         .PWMWIDTH(PWMWIDTH),
         .RESET_CMP(RESET_CMP)
`ifdef PWM_CMP_CLAMP_EN
         ,
         .CMP_MIN(CMP_MIN),
         .CMP_MAX(CMP_MAX)
`endif
      ) u_ch (
         .clk1d(clk1d),
         .rst(rst),
         .byte_we(byte_we),
         .wdata(reg_data),
         .commit(commit),
         .imm_mode(imm_mode),
         .period_start(period_start[c]),
         .cmp(cmp_out[c*PWMWIDTH +: PWMWIDTH]),
         .pending(pending[c]),
         .update(update[c])
`ifdef PWM_CMP_CLAMP_EN
         ,
         .clamp_hit(clamp_hit[c])
`endif
      );
   end
endmodule

// File: tb/tb_pwm_regbank.sv
// tb_pwm_regbank: scoreboard bench for pwm_regbank (NCH=2, PWMWIDTH=19)
module tb_pwm_regbank;
   localparam int NCH = 2;
   localparam int PW = 19;
   localparam int RB = 4;
   logic clk1d = 1'b0;
   logic rst = 1'b1;
   logic [RB-1:0] reg_addr = '0;
   logic [7:0] reg_data = '0;
   logic reg_valid = 1'b0;
   logic [NCH-1:0] period_start = '0;
   logic [NCH*PW-1:0] cmp_out;
   logic [NCH-1:0] pending, update;
   logic addr_err;
`ifdef PWM_CMP_CLAMP_EN
   logic [NCH-1:0] clamp_hit;
`endif
   int tests = 0;
   int fails = 0;
   logic [PW-1:0] exp_q [NCH][$];
   logic [PW-1:0] sb_e;

   always #5 clk1d = ~clk1d;

   pwm_regbank #(
      .NCH(NCH), .PWMWIDTH(PW), .REGBITS(RB)
`ifdef PWM_CMP_CLAMP_EN
      , .CMP_MAX(19'h60000)
`endif
   ) dut (
      .clk1d(clk1d), .rst(rst), .reg_addr(reg_addr), .reg_data(reg_data),
      .reg_valid(reg_valid), .period_start(period_start), .cmp_out(cmp_out),
      .pending(pending), .update(update), .addr_err(addr_err)
`ifdef PWM_CMP_CLAMP_EN
      , .clamp_hit(clamp_hit)
`endif
   );

   function automatic logic [PW-1:0] ch(input int c);
      return cmp_out[c*PW +: PW];
   endfunction

   // every update pulse must match the oldest expected value for its channel
   always @(negedge clk1d)
      if (!rst)
         for (int c = 0; c < NCH; c++)
            if (update[c]) begin
               tests++;
               if (exp_q[c].size() == 0) begin
                  fails++;
                  $display("FAIL sb_unexpected_update ch%0d cmp=%h expected no update", c, ch(c));
               end else begin
                  sb_e = exp_q[c].pop_front();
                  if (ch(c) !== sb_e) begin
                     fails++;
                     $display("FAIL sb_update_value ch%0d got=%h exp=%h", c, ch(c), sb_e);
                  end
               end
            end

   task automatic tick(input int n);
      repeat (n) @(negedge clk1d);
   endtask

   task automatic wr(input logic [RB-1:0] a, input logic [7:0] d);
      @(negedge clk1d);
      reg_addr = a;
      reg_data = d;
      reg_valid = 1'b1;
      @(negedge clk1d);
      reg_valid = 1'b0;
   endtask

   task automatic pulse(input logic [NCH-1:0] ps);
      @(negedge clk1d);
      period_start = ps;
      @(negedge clk1d);
      period_start = '0;
   endtask

   task automatic test_reset;
      reg_addr = 4'd3;
      reg_valid = 1'b1;
      tick(3);
      reg_valid = 1'b0;
      rst = 1'b0;
      tests++; if (ch(0) !== 19'h50001) begin fails++; $display("FAIL reset_cmp0 got=%h exp=%h", ch(0), 19'h50001); end
      tests++; if (ch(1) !== 19'h50001) begin fails++; $display("FAIL reset_cmp1 got=%h exp=%h", ch(1), 19'h50001); end
      tests++; if (pending !== 2'b00) begin fails++; $display("FAIL reset_pending got=%b exp=00", pending); end
      tests++; if (addr_err !== 1'b0) begin fails++; $display("FAIL reset_addr_err got=%b exp=0", addr_err); end
      tick(2);
      tests++; if (update !== 2'b00 || pending !== 2'b00) begin fails++; $display("FAIL reset_quiet update=%b pending=%b exp 00/00", update, pending); end
   endtask

   task automatic test_commit_boundary;
      wr(4, 8'h34);
      wr(5, 8'h12);
      wr(6, 8'h07);
      wr(7, 8'h00);
      tests++; if (pending !== 2'b10) begin fails++; $display("FAIL commit_pending got=%b exp=10", pending); end
      tick(3);
      tests++; if (ch(1) !== 19'h50001) begin fails++; $display("FAIL commit_hold got=%h exp=%h", ch(1), 19'h50001); end
      pulse(2'b10);
      exp_q[1].push_back(19'h71234);
      tests++; if (ch(1) !== 19'h71234) begin fails++; $display("FAIL boundary_cmp1 got=%h exp=%h", ch(1), 19'h71234); end
      tests++; if (pending !== 2'b00 || update !== 2'b00) begin fails++; $display("FAIL boundary_state pending=%b update=%b exp 00/00", pending, update); end
      @(negedge clk1d);
      tests++; if (update !== 2'b10) begin fails++; $display("FAIL boundary_update got=%b exp=10", update); end
      tests++; if (ch(0) !== 19'h50001) begin fails++; $display("FAIL boundary_cmp0 got=%h exp=%h", ch(0), 19'h50001); end
      tick(2);
   endtask

   task automatic test_atomic;
      wr(0, 8'h00);
      wr(1, 8'h01);
      wr(2, 8'h00);
      wr(3, 8'h00);
      wr(1, 8'h02);
      pulse(2'b01);
      exp_q[0].push_back(19'h00100);
      tests++; if (ch(0) !== 19'h00100) begin fails++; $display("FAIL atomic_cmp0 got=%h exp=%h", ch(0), 19'h00100); end
      tick(2);
   endtask

   task automatic test_same_cycle;
      @(negedge clk1d);
      reg_addr = 4'd3;
      reg_valid = 1'b1;
      period_start = 2'b01;
      @(negedge clk1d);
      reg_valid = 1'b0;
      period_start = '0;
      tests++; if (ch(0) !== 19'h00100 || pending !== 2'b01) begin fails++; $display("FAIL same_idle cmp0=%h pending=%b exp 00100/01", ch(0), pending); end
      tick(3);
      pulse(2'b01);
      exp_q[0].push_back(19'h00200);
      tests++; if (ch(0) !== 19'h00200) begin fails++; $display("FAIL same_next cmp0=%h exp=%h", ch(0), 19'h00200); end
      tick(2);
      wr(0, 8'h55);
      wr(3, 8'h00);
      wr(0, 8'h66);
      @(negedge clk1d);
      reg_addr = 4'd3;
      reg_valid = 1'b1;
      period_start = 2'b01;
      @(negedge clk1d);
      reg_valid = 1'b0;
      period_start = '0;
      exp_q[0].push_back(19'h00255);
      tests++; if (ch(0) !== 19'h00255 || pending !== 2'b01) begin fails++; $display("FAIL same_pending cmp0=%h pending=%b exp 00255/01", ch(0), pending); end
      tick(2);
      pulse(2'b01);
      exp_q[0].push_back(19'h00266);
      tests++; if (ch(0) !== 19'h00266 || pending !== 2'b00) begin fails++; $display("FAIL same_last cmp0=%h pending=%b exp 00266/00", ch(0), pending); end
      tick(2);
   endtask

   task automatic test_imm;
      wr(1, 8'h77);
      wr(4, 8'hAB);
      wr(3, 8'h00);
      wr(7, 8'h00);
      wr(8, 8'h03);
      exp_q[0].push_back(19'h07766);
      exp_q[1].push_back(19'h712AB);
      tests++; if (pending !== 2'b11 || ch(0) !== 19'h00266) begin fails++; $display("FAIL imm_staged pending=%b cmp0=%h exp 11/00266", pending, ch(0)); end
      @(negedge clk1d);
      tests++; if (ch(0) !== 19'h07766 || ch(1) !== 19'h712AB) begin fails++; $display("FAIL imm_apply cmp0=%h cmp1=%h exp 07766/712ab", ch(0), ch(1)); end
      tests++; if (pending !== 2'b00) begin fails++; $display("FAIL imm_pending_clear got=%b exp=00", pending); end
      @(negedge clk1d);
      tests++; if (update !== 2'b11) begin fails++; $display("FAIL imm_update got=%b exp=11", update); end
      wr(0, 8'h11);
      wr(3, 8'h00);
      exp_q[0].push_back(19'h07711);
      tests++; if (pending !== 2'b01) begin fails++; $display("FAIL imm_one_pending got=%b exp=01", pending); end
      @(negedge clk1d);
      tests++; if (pending !== 2'b00 || ch(0) !== 19'h07711) begin fails++; $display("FAIL imm_one_apply pending=%b cmp0=%h exp 00/07711", pending, ch(0)); end
      tick(1);
      wr(8, 8'h00);
      wr(4, 8'h00);
      wr(7, 8'h00);
      tick(2);
      tests++; if (pending !== 2'b10 || ch(1) !== 19'h712AB) begin fails++; $display("FAIL flush_wait pending=%b cmp1=%h exp 10/712ab", pending, ch(1)); end
      wr(8, 8'h02);
      exp_q[1].push_back(19'h71200);
      tests++; if (pending !== 2'b10) begin fails++; $display("FAIL flush_latency pending=%b exp=10", pending); end
      @(negedge clk1d);
      tests++; if (pending !== 2'b00 || ch(1) !== 19'h71200) begin fails++; $display("FAIL flush_apply pending=%b cmp1=%h exp 00/71200", pending, ch(1)); end
      tick(1);
      wr(8, 8'h00);
   endtask

   task automatic test_addr_err;
      wr(9, 8'hFF);
      tests++; if (addr_err !== 1'b1) begin fails++; $display("FAIL addr_err_pulse got=%b exp=1", addr_err); end
      tests++; if (pending !== 2'b00 || ch(0) !== 19'h07711 || ch(1) !== 19'h71200) begin fails++; $display("FAIL addr_err_state pending=%b cmp0=%h cmp1=%h", pending, ch(0), ch(1)); end
      @(negedge clk1d);
      tests++; if (addr_err !== 1'b0) begin fails++; $display("FAIL addr_err_width got=%b exp=0", addr_err); end
      wr(8, 8'h00);
      tests++; if (addr_err !== 1'b0) begin fails++; $display("FAIL addr_err_ctrl got=%b exp=0", addr_err); end
      wr(15, 8'h03);
      tests++; if (addr_err !== 1'b1 || pending !== 2'b00) begin fails++; $display("FAIL addr_err_top err=%b pending=%b exp 1/00", addr_err, pending); end
      tick(2);
   endtask

`ifdef PWM_CMP_CLAMP_EN
   task automatic test_clamp;
      wr(0, 8'hFF);
      wr(1, 8'hFF);
      wr(2, 8'h07);
      wr(3, 8'h00);
      tests++; if (clamp_hit !== 2'b01) begin fails++; $display("FAIL clamp_hit_set got=%b exp=01", clamp_hit); end
      pulse(2'b01);
      exp_q[0].push_back(19'h60000);
      tests++; if (ch(0) !== 19'h60000) begin fails++; $display("FAIL clamp_value got=%h exp=%h", ch(0), 19'h60000); end
      wr(2, 8'h00);
      wr(3, 8'h00);
      tests++; if (clamp_hit !== 2'b00) begin fails++; $display("FAIL clamp_hit_clear got=%b exp=00", clamp_hit); end
      pulse(2'b01);
      exp_q[0].push_back(19'h0FFFF);
      tick(2);
   endtask
`endif

   task automatic test_reset_mid_pending;
      wr(0, 8'h99);
      wr(3, 8'h00);
      tests++; if (pending !== 2'b01) begin fails++; $display("FAIL midrst_pre pending=%b exp=01", pending); end
      @(negedge clk1d);
      #2 rst = 1'b1;
      #1;
      tests++; if (pending !== 2'b00 || ch(0) !== 19'h50001 || ch(1) !== 19'h50001) begin fails++; $display("FAIL midrst_async pending=%b cmp0=%h cmp1=%h", pending, ch(0), ch(1)); end
      @(negedge clk1d);
      reg_addr = 4'd7;
      reg_valid = 1'b1;
      @(negedge clk1d);
      reg_valid = 1'b0;
      rst = 1'b0;
      tick(2);
      tests++; if (pending !== 2'b00 || update !== 2'b00) begin fails++; $display("FAIL midrst_after pending=%b update=%b exp 00/00", pending, update); end
      pulse(2'b11);
      tests++; if (ch(0) !== 19'h50001 || ch(1) !== 19'h50001) begin fails++; $display("FAIL midrst_no_apply cmp0=%h cmp1=%h exp 50001", ch(0), ch(1)); end
      tick(3);
   endtask

   initial begin
      test_reset;
      test_commit_boundary;
      test_atomic;
      test_same_cycle;
      test_imm;
      test_addr_err;
`ifdef PWM_CMP_CLAMP_EN
      test_clamp;
`endif
      test_reset_mid_pending;
      for (int c = 0; c < NCH; c++) begin
         tests++;
         if (exp_q[c].size() != 0) begin
            fails++;
            $display("FAIL sb_leftover ch%0d got=%0d pending entries exp=0", c, exp_q[c].size());
         end
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
